irq_ctrl_sb_ctrl: RTL and testbench

Memory-mapped interrupt controller that sits between the peripheral controllers and the core. It is the responder end of the peripherals' interrupt_request_o / interrupt_return_i handshake, and the initiator toward the core's irq_req_i / irq_ret_o pair. It arbitrates N maskable level requests by fixed priority. It holds one source active until the core returns from the handler, then pulses that source's return line. It is programmed over the same system-bus slot protocol as the other *_sb_ctrl peripherals.

---
 rtl/irq_ctrl_pkg.sv | 24 ++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_ctrl_sb_ctrl.sv | 122 ++++++++++++
 tb/tb_irq_ctrl_sb_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and register map for the system-bus interrupt controller.
// The state enum, bus offsets and the source-count ceiling live here.
package irq_ctrl_pkg;

  localparam int N_SRC_MAX = 32;
  localparam int ID_W      = 5;

  localparam logic [7:0] OFF_MASK   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_ACTIVE = 8'h08;
  localparam logic [7:0] OFF_RESET  = 8'h24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } irq_state_t;

  // ACTIVE register layout: flag in bit 31, source id in the low bits.
  function automatic logic [31:0] active_word(input logic flag, input logic [ID_W-1:0] id);
    return {flag, 26'd0, id};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: source 0 wins over every other source.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] vec,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Scanning from the top down lets the lowest set bit overwrite the rest.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_sb_ctrl.sv
// Interrupt controller on the system-bus slot: masks and arbitrates level
// requests, holds one source active until the core returns, then pulses it.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a masked request; winner latched on entry to ACTIVE
//   ST_ACTIVE | core_irq_req_o high, waiting for core_irq_ret_i
//   ST_GAP    | one cycle, return pulse on irq_ret_o, no arbitration
module irq_ctrl_sb_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             write_enable_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      write_data_i,
  output logic [31:0]      read_data_o,
  input  logic [N_SRC-1:0] irq_req_i,
  output logic [N_SRC-1:0] irq_ret_o,
  output logic             core_irq_req_o,
  input  logic             core_irq_ret_i
);

  localparam logic [N_SRC-1:0] SRC_ONE = N_SRC'(1);

  irq_state_t       state;
  logic [N_SRC-1:0] mask;
  logic [ID_W-1:0]  act_id;
  logic [N_SRC-1:0] masked;
  logic             win_valid;
  logic [ID_W-1:0]  win_id;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             rd_en;
  logic             soft_rst;
  logic             rst_all;
  logic [N_SRC-1:0] ret_onehot;

  // Only the low byte of the address is decoded; the rest is don't-care.
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:8], write_data_i};

  assign wr_en      = req_i &  write_enable_i;
  assign rd_en      = req_i & ~write_enable_i;
  assign soft_rst   = wr_en && (addr_i[7:0] == OFF_RESET) && write_data_i[0];
  assign rst_all    = rst_i | soft_rst;
  assign masked     = irq_req_i & mask;
  assign ret_onehot = SRC_ONE << act_id;

  irq_prio_enc #(
    .N_SRC(N_SRC)
  ) u_prio_enc (
    .vec  (masked),
    .valid(win_valid),
    .id   (win_id)
  );

  always_comb begin
    rd_mux = 32'd0;
    case (addr_i[7:0])
      OFF_MASK:   rd_mux = 32'(mask);
      OFF_STATUS: rd_mux = 32'(masked);
      OFF_ACTIVE: rd_mux = active_word(state == ST_ACTIVE, act_id);
      default:    rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_all) begin
      mask        <= '0;
      read_data_o <= 32'd0;
    end else begin
      if (wr_en && (addr_i[7:0] == OFF_MASK)) begin
        mask <= write_data_i[N_SRC-1:0];
      end
      if (rd_en) begin
        read_data_o <= rd_mux;
      end
    end
  end

  // Mask changes and a dropped level are deliberately ignored while ACTIVE:
  // the return always goes to the id latched at entry.
  always_ff @(posedge clk_i) begin
    if (rst_all) begin
      state          <= ST_IDLE;
      act_id         <= '0;
      core_irq_req_o <= 1'b0;
      irq_ret_o      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            act_id         <= win_id;
            core_irq_req_o <= 1'b1;
            state          <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (core_irq_ret_i) begin
            core_irq_req_o <= 1'b0;
            irq_ret_o      <= ret_onehot;
            state          <= ST_GAP;
          end
        end
        ST_GAP: begin
          irq_ret_o <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          core_irq_req_o <= 1'b0;
          irq_ret_o      <= '0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl_sb_ctrl.sv
// Self-checking bench for irq_ctrl_sb_ctrl: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a behavioural model.
module tb_irq_ctrl_sb_ctrl;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [31:0]   addr;
  logic [31:0]   wd;
  logic [31:0]   rd;
  logic [N-1:0]  irq_req;
  logic [N-1:0]  irq_ret;
  logic          core_req;
  logic          core_ret;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the controller's visible state.
  logic [N-1:0]  m_mask;
  bit            m_busy;
  bit            m_gap;
  int            m_id;
  logic [31:0]   m_rd;
  logic [N-1:0]  m_ret;

  always #5 clk = ~clk;

  irq_ctrl_sb_ctrl #(.N_SRC(N)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .write_enable_i(we),
    .addr_i        (addr),
    .write_data_i  (wd),
    .read_data_o   (rd),
    .irq_req_i     (irq_req),
    .irq_ret_o     (irq_ret),
    .core_irq_req_o(core_req),
    .core_irq_ret_i(core_ret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [N-1:0] v);
    logic [N-1:0] iso;
    int r;
    iso = v & (~v + 1'b1);
    r = 0;
    for (int i = 0; i < N; i++) if (iso[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return 32'(m_mask);
      8'h04:   return 32'(irq_req & m_mask);
      8'h08:   return {m_busy, 26'd0, 5'(m_id)};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: advance the model on the current inputs, then compare outputs.
  task automatic step();
    bit            srst;
    logic [N-1:0]  n_mask;
    bit            n_busy, n_gap;
    int            n_id;
    logic [31:0]   n_rd;
    logic [N-1:0]  n_ret;
    logic [N-1:0]  pend;
    srst   = req && we && (addr[7:0] == 8'h24) && wd[0];
    n_mask = m_mask; n_busy = m_busy; n_gap = m_gap; n_id = m_id;
    n_rd   = m_rd;   n_ret  = m_ret;
    if (rst || srst) begin
      n_mask = '0; n_busy = 0; n_gap = 0; n_id = 0; n_rd = 0; n_ret = '0;
    end else begin
      if (req && !we) n_rd = model_read(addr[7:0]);
      if (req && we && addr[7:0] == 8'h00) n_mask = wd[N-1:0];
      pend = irq_req & m_mask;
      if (m_gap) begin
        n_gap = 0; n_ret = '0;
      end else if (m_busy) begin
        if (core_ret) begin
          n_busy = 0; n_gap = 1; n_ret = N'(1) << m_id;
        end
      end else if (pend != '0) begin
        n_busy = 1; n_id = lowest_set(pend);
      end
    end
    @(posedge clk);
    #1;
    m_mask = n_mask; m_busy = n_busy; m_gap = n_gap; m_id = n_id;
    m_rd = n_rd; m_ret = n_ret;
    check("core_req", 32'(core_req), 32'(m_busy));
    check("irq_ret",  32'(irq_ret),  32'(m_ret));
    check("rdata",    rd,            m_rd);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = {24'd0, a}; wd = d;
    step();
    req = 1'b0; we = 1'b0; wd = 32'd0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = {24'd0, a};
    step();
    req = 1'b0;
    d = rd;
  endtask

  initial begin
    logic [31:0] v;
    int lows;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wd = 32'd0;
    irq_req = 8'hFF; core_ret = 1'b0;
    m_mask = '0; m_busy = 0; m_gap = 0; m_id = 0; m_rd = 0; m_ret = '0;

    // Reset with every request high
    step(); step();
    rst = 1'b0;
    step(); step();
    check("rst_core_req", 32'(core_req), 32'd0);
    bus_read(8'h00, v); check("rst_mask", v, 32'd0);
    bus_read(8'h08, v); check("rst_active", v, 32'd0);

    // Priority: 0x28 -> source 3
    irq_req = 8'h00;
    bus_write(8'h00, 32'hFF);
    irq_req = 8'h28;
    step();
    check("prio_core_req", 32'(core_req), 32'd1);
    bus_read(8'h08, v); check("prio_active", v, 32'h8000_0003);
    core_ret = 1'b1; irq_req = 8'h00;
    step();
    core_ret = 1'b0;
    check("prio_ret", 32'(irq_ret), 32'h08);
    step();
    check("prio_ret_once", 32'(irq_ret), 32'h00);
    step(); step();

    // Non-preemption, then one GAP cycle before source 0 wins
    irq_req = 8'h08;
    step();
    irq_req = 8'h09;
    step();
    bus_read(8'h08, v); check("nopreempt_active", v, 32'h8000_0003);
    core_ret = 1'b1; irq_req = 8'h01;
    lows = 0;
    step(); core_ret = 1'b0;
    if (!core_req) lows++;
    step(); if (!core_req) lows++;
    step(); if (!core_req) lows++;
    check("gap_low_cycles", 32'(lows), 32'd2);
    bus_read(8'h08, v); check("next_active", v, 32'h8000_0000);
    core_ret = 1'b1; irq_req = 8'h00;
    step(); core_ret = 1'b0;
    step(); step();

    // Masking
    bus_write(8'h00, 32'h04);
    irq_req = 8'h03;
    step(); step();
    check("mask_no_req", 32'(core_req), 32'd0);
    bus_read(8'h04, v); check("mask_status", v, 32'd0);
    irq_req = 8'h07;
    step();
    bus_read(8'h08, v); check("mask_active", v, 32'h8000_0002);

    // Active source drops mid-ACTIVE: still active, return to latched id
    irq_req = 8'h00;
    step(); step();
    check("drop_still_req", 32'(core_req), 32'd1);
    core_ret = 1'b1;
    step(); core_ret = 1'b0;
    check("drop_ret", 32'(irq_ret), 32'h04);
    step(); step();

    // Spurious return in IDLE
    core_ret = 1'b1;
    step(); core_ret = 1'b0;
    check("spurious_ret", 32'(irq_ret), 32'h00);
    step();

    // Soft reset mid-ACTIVE
    bus_write(8'h00, 32'hFF);
    irq_req = 8'h10;
    step();
    check("srst_pre_req", 32'(core_req), 32'd1);
    bus_write(8'h24, 32'h1);
    check("srst_core_req", 32'(core_req), 32'd0);
    core_ret = 1'b1;
    step(); core_ret = 1'b0;
    step(); step();
    check("srst_no_ret", 32'(irq_ret), 32'h00);
    bus_read(8'h00, v); check("srst_mask", v, 32'd0);
    irq_req = 8'h00;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int sel;
      rst      = ($urandom_range(0, 299) == 0);
      req      = ($urandom_range(0, 2) == 0);
      we       = $urandom_range(0, 1);
      sel      = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: addr = 32'h00;
        3, 4:    addr = 32'h04;
        5, 6:    addr = 32'h08;
        7:       addr = ($urandom_range(0, 7) == 0) ? 32'h24 : 32'h10;
        8:       addr = {$urandom, 8'h00} & 32'hFFFF_FF00;
        default: addr = {24'd0, 8'($urandom)};
      endcase
      wd       = $urandom;
      irq_req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      core_ret = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0; req = 1'b0; core_ret = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
